// File: rtl/csr_trap_sequencer_pkg.sv
// Shared definitions for the CSR trap sequencer.
// Holds the FSM state enum, CSR addresses, the machine external interrupt
// cause, mstatus/mie bit positions, the CSR request payload, and the
// mstatus transforms applied on trap entry and on mret.
package csr_trap_sequencer_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned CSR_ADDR_W = 12;
    localparam int unsigned CAUSE_W    = 5;

    localparam logic [CSR_ADDR_W-1:0] CSR_MSTATUS = 12'h300;
    localparam logic [CSR_ADDR_W-1:0] CSR_MIE     = 12'h304;
    localparam logic [CSR_ADDR_W-1:0] CSR_MTVEC   = 12'h305;
    localparam logic [CSR_ADDR_W-1:0] CSR_MEPC    = 12'h341;
    localparam logic [CSR_ADDR_W-1:0] CSR_MCAUSE  = 12'h342;

    localparam logic [XLEN-1:0] IRQ_CAUSE_MEI = 32'h8000_000B;

    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;
    localparam int unsigned MSTATUS_MPP_LSB  = 11;
    localparam int unsigned MIE_MEIE_BIT     = 11;

    typedef enum logic [3:0] {
        IDLE,
        TRAP_RD_MTVEC,
        TRAP_RD_MST,
        TRAP_WR_MEPC,
        TRAP_WR_MCAUSE,
        TRAP_WR_MST,
        MRET_RD_MEPC,
        MRET_RD_MST,
        MRET_WR_MST,
        REDIRECT
    } state_e;

    // One access on the CSR file port.
    typedef struct packed {
        logic [CSR_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       wdata;
        logic                  re;
        logic                  we;
    } csr_req_t;

    // Trap entry: stash MIE in MPIE, disable interrupts, enter M-mode.
    function automatic logic [XLEN-1:0] mstatus_on_trap(input logic [XLEN-1:0] ms);
        logic [XLEN-1:0] r;
        r                        = ms;
        r[MSTATUS_MPIE_BIT]      = ms[MSTATUS_MIE_BIT];
        r[MSTATUS_MIE_BIT]       = 1'b0;
        r[MSTATUS_MPP_LSB +: 2]  = 2'b11;
        return r;
    endfunction

    // mret: restore MIE from MPIE and set MPIE.
    function automatic logic [XLEN-1:0] mstatus_on_mret(input logic [XLEN-1:0] ms);
        logic [XLEN-1:0] r;
        r                   = ms;
        r[MSTATUS_MIE_BIT]  = ms[MSTATUS_MPIE_BIT];
        r[MSTATUS_MPIE_BIT] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/csr_trap_sequencer_if.sv
// CSR file port bundle.
// master: the sequencer (drives address/data/enables, receives read data).
// slave : the CSR file (read data is registered, valid the cycle after
//         csr_read_enable_o).
interface csr_trap_sequencer_if;
    import csr_trap_sequencer_pkg::*;

    logic [CSR_ADDR_W-1:0] csr_address_o;
    logic [XLEN-1:0]       csr_write_data_o;
    logic                  csr_read_enable_o;
    logic                  csr_write_enable_o;
    logic [XLEN-1:0]       csr_read_data_i;

    modport master (
        output csr_address_o, csr_write_data_o, csr_read_enable_o, csr_write_enable_o,
        input  csr_read_data_i
    );

    modport slave (
        input  csr_address_o, csr_write_data_o, csr_read_enable_o, csr_write_enable_o,
        output csr_read_data_i
    );
endinterface

// File: rtl/csr_trap_sequencer_trap_target_calc.sv
// trap_target_calc: combinational trap target PC.
// Ports: mtvec_i (trap vector CSR), cause_i (low cause bits), irq_i (trap is
// an interrupt), target_o (redirect PC).
// Macro CSR_TRAP_VECTORED_EN: when defined, interrupts with mtvec mode 2'b01
// vector to base + 4*cause; otherwise the mode bits are ignored.
module trap_target_calc
    import csr_trap_sequencer_pkg::*;
(
    input  logic [XLEN-1:0]    mtvec_i,
    input  logic [CAUSE_W-1:0] cause_i,
    input  logic               irq_i,
    output logic [XLEN-1:0]    target_o
);

    logic [XLEN-1:0] base_c;
    assign base_c = {mtvec_i[XLEN-1:2], 2'b00};

`ifdef CSR_TRAP_VECTORED_EN
    assign target_o = (irq_i && (mtvec_i[1:0] == 2'b01))
                    ? base_c + XLEN'({cause_i, 2'b00})
                    : base_c;
`else
    logic unused_c;
    assign unused_c = ^{mtvec_i[1:0], cause_i, irq_i};
    assign target_o = base_c;
`endif

endmodule

// File: rtl/csr_trap_sequencer.sv
// csr_trap_sequencer: sole owner of the CSR file port. Sequences trap entry
// (exception or machine external interrupt) and mret through CSR reads and
// writes, and lets pipeline CSR accesses through while idle.
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   exc_valid_i/exc_cause_i/exc_pc_i  exception request
//   mret_i                        mret request
//   irq_i/irq_pc_i                external interrupt level and resume PC
//   ack_o                         event accepted (pulse in accept cycle)
//   busy_o                        sequencer not idle
//   redirect_valid_o/redirect_pc_o  fetch redirect
//   pipe_csr_*                    pipeline CSR access (granted when idle)
//   csr_if (master)               CSR file port
// Macro CSR_TRAP_VECTORED_EN selects vectored interrupt targets (see
// trap_target_calc).
module csr_trap_sequencer
    import csr_trap_sequencer_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  exc_valid_i,
    input  logic [CAUSE_W-1:0]    exc_cause_i,
    input  logic [XLEN-1:0]       exc_pc_i,
    input  logic                  mret_i,
    input  logic                  irq_i,
    input  logic [XLEN-1:0]       irq_pc_i,
    output logic                  ack_o,
    output logic                  busy_o,
    output logic                  redirect_valid_o,
    output logic [XLEN-1:0]       redirect_pc_o,
    input  logic [CSR_ADDR_W-1:0] pipe_csr_addr_i,
    input  logic [XLEN-1:0]       pipe_csr_wdata_i,
    input  logic                  pipe_csr_re_i,
    input  logic                  pipe_csr_we_i,
    output logic                  pipe_csr_gnt_o,
    output logic [XLEN-1:0]       pipe_csr_rdata_o,
    csr_trap_sequencer_if.master  csr_if
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic            is_irq_q, is_irq_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mstatus_q, mstatus_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic            mie_sh_q, mie_sh_d;
    logic            meie_sh_q, meie_sh_d;
    logic            busy_q, busy_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

    logic            ack_c;
    logic            gnt_c;
    logic            irq_take_c;
    csr_req_t        req_c;
    logic [XLEN-1:0] trap_target_c;

    trap_target_calc u_target (
        .mtvec_i  (mtvec_q),
        .cause_i  (cause_q[CAUSE_W-1:0]),
        .irq_i    (is_irq_q),
        .target_o (trap_target_c)
    );

    assign irq_take_c = irq_i && mie_sh_q && meie_sh_q;

    // Next state, CSR port drive, captures and shadow tracking.
    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        cause_d          = cause_q;
        is_irq_d         = is_irq_q;
        mtvec_d          = mtvec_q;
        mstatus_d        = mstatus_q;
        mepc_d           = mepc_q;
        mie_sh_d         = mie_sh_q;
        meie_sh_d        = meie_sh_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        ack_c            = 1'b0;
        gnt_c            = 1'b0;
        req_c            = '0;

        case (state_q)
            IDLE: begin
                if (exc_valid_i) begin
                    ack_c    = 1'b1;
                    pc_d     = exc_pc_i;
                    cause_d  = XLEN'(exc_cause_i);
                    is_irq_d = 1'b0;
                    state_d  = TRAP_RD_MTVEC;
                end else if (mret_i) begin
                    ack_c    = 1'b1;
                    state_d  = MRET_RD_MEPC;
                end else if (irq_take_c) begin
                    ack_c    = 1'b1;
                    pc_d     = irq_pc_i;
                    cause_d  = IRQ_CAUSE_MEI;
                    is_irq_d = 1'b1;
                    state_d  = TRAP_RD_MTVEC;
                end else begin
                    gnt_c       = 1'b1;
                    req_c.addr  = pipe_csr_addr_i;
                    req_c.wdata = pipe_csr_wdata_i;
                    req_c.re    = pipe_csr_re_i;
                    req_c.we    = pipe_csr_we_i;
                end
            end
            TRAP_RD_MTVEC: begin
                req_c.addr = CSR_MTVEC;
                req_c.re   = 1'b1;
                state_d    = TRAP_RD_MST;
            end
            TRAP_RD_MST: begin
                mtvec_d    = csr_if.csr_read_data_i;
                req_c.addr = CSR_MSTATUS;
                req_c.re   = 1'b1;
                state_d    = TRAP_WR_MEPC;
            end
            TRAP_WR_MEPC: begin
                mstatus_d   = csr_if.csr_read_data_i;
                req_c.addr  = CSR_MEPC;
                req_c.wdata = pc_q;
                req_c.we    = 1'b1;
                state_d     = TRAP_WR_MCAUSE;
            end
            TRAP_WR_MCAUSE: begin
                req_c.addr  = CSR_MCAUSE;
                req_c.wdata = cause_q;
                req_c.we    = 1'b1;
                state_d     = TRAP_WR_MST;
            end
            TRAP_WR_MST: begin
                req_c.addr       = CSR_MSTATUS;
                req_c.wdata      = mstatus_on_trap(mstatus_q);
                req_c.we         = 1'b1;
                state_d          = REDIRECT;
                redirect_valid_d = 1'b1;
                redirect_pc_d    = trap_target_c;
            end
            MRET_RD_MEPC: begin
                req_c.addr = CSR_MEPC;
                req_c.re   = 1'b1;
                state_d    = MRET_RD_MST;
            end
            MRET_RD_MST: begin
                mepc_d     = csr_if.csr_read_data_i;
                req_c.addr = CSR_MSTATUS;
                req_c.re   = 1'b1;
                state_d    = MRET_WR_MST;
            end
            MRET_WR_MST: begin
                // mstatus read data arrives this cycle; write it back directly.
                mstatus_d        = csr_if.csr_read_data_i;
                req_c.addr       = CSR_MSTATUS;
                req_c.wdata      = mstatus_on_mret(csr_if.csr_read_data_i);
                req_c.we         = 1'b1;
                state_d          = REDIRECT;
                redirect_valid_d = 1'b1;
                redirect_pc_d    = mepc_q;
            end
            REDIRECT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Interrupt enable shadows follow every mstatus/mie write on the port.
        if (req_c.we) begin
            if (req_c.addr == CSR_MSTATUS) mie_sh_d  = req_c.wdata[MSTATUS_MIE_BIT];
            if (req_c.addr == CSR_MIE)     meie_sh_d = req_c.wdata[MIE_MEIE_BIT];
        end

        busy_d = (state_d != IDLE);
    end

    // State and capture registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q          <= IDLE;
            pc_q             <= '0;
            cause_q          <= '0;
            is_irq_q         <= 1'b0;
            mtvec_q          <= '0;
            mstatus_q        <= '0;
            mepc_q           <= '0;
            mie_sh_q         <= 1'b0;
            meie_sh_q        <= 1'b0;
            busy_q           <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            cause_q          <= cause_d;
            is_irq_q         <= is_irq_d;
            mtvec_q          <= mtvec_d;
            mstatus_q        <= mstatus_d;
            mepc_q           <= mepc_d;
            mie_sh_q         <= mie_sh_d;
            meie_sh_q        <= meie_sh_d;
            busy_q           <= busy_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    // Accept, grant and CSR passthrough are same-cycle; hold them low in reset.
    assign ack_o            = rst_ni & ack_c;
    assign pipe_csr_gnt_o   = rst_ni & gnt_c;
    assign pipe_csr_rdata_o = rst_ni ? csr_if.csr_read_data_i : '0;
    assign busy_o           = busy_q;
    assign redirect_valid_o = redirect_valid_q;
    assign redirect_pc_o    = redirect_pc_q;

    assign csr_if.csr_address_o      = rst_ni ? req_c.addr  : '0;
    assign csr_if.csr_write_data_o   = rst_ni ? req_c.wdata : '0;
    assign csr_if.csr_read_enable_o  = rst_ni & req_c.re;
    assign csr_if.csr_write_enable_o = rst_ni & req_c.we;

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// Self-checking bench for csr_trap_sequencer with a registered CSR file model.
module tb_csr_trap_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exc_valid;
    logic [4:0]  exc_cause;
    logic [31:0] exc_pc;
    logic        mret;
    logic        irq;
    logic [31:0] irq_pc;
    logic        ack;
    logic        busy;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [11:0] pipe_addr;
    logic [31:0] pipe_wdata;
    logic        pipe_re;
    logic        pipe_we;
    logic        pipe_gnt;
    logic [31:0] pipe_rdata;

    csr_trap_sequencer_if cif ();

    csr_trap_sequencer dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .exc_valid_i      (exc_valid),
        .exc_cause_i      (exc_cause),
        .exc_pc_i         (exc_pc),
        .mret_i           (mret),
        .irq_i            (irq),
        .irq_pc_i         (irq_pc),
        .ack_o            (ack),
        .busy_o           (busy),
        .redirect_valid_o (redirect_valid),
        .redirect_pc_o    (redirect_pc),
        .pipe_csr_addr_i  (pipe_addr),
        .pipe_csr_wdata_i (pipe_wdata),
        .pipe_csr_re_i    (pipe_re),
        .pipe_csr_we_i    (pipe_we),
        .pipe_csr_gnt_o   (pipe_gnt),
        .pipe_csr_rdata_o (pipe_rdata),
        .csr_if           (cif)
    );

    always #5 clk = ~clk;

`ifdef CSR_TRAP_VECTORED_EN
    localparam logic [31:0] IRQ_TARGET = 32'h8000_102C;
`else
    localparam logic [31:0] IRQ_TARGET = 32'h8000_1000;
`endif

    // CSR file model: registered read data, write on the clock edge.
    logic [31:0] csr_mem [4096];
    always @(posedge clk) begin
        if (cif.csr_write_enable_o) csr_mem[cif.csr_address_o] <= cif.csr_write_data_o;
        if (cif.csr_read_enable_o)  cif.csr_read_data_i <= csr_mem[cif.csr_address_o];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        int          cyc;
    } exp_redirect_t;
    exp_redirect_t sb_q[$];
    logic [31:0]   rd_q[$];

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [31:0] data;
    } pvec_t;
    pvec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Redirect monitor: every redirect pulse must match the next expected one.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && redirect_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_redirect: pc 0x%08h at cycle %0d, none expected", redirect_pc, cyc);
            end else begin
                exp_redirect_t e;
                e = sb_q.pop_front();
                chk("redirect_pc", redirect_pc, e.pc);
                chk("redirect_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic pipe_wr(input logic [11:0] a, input logic [31:0] d);
        pipe_addr  = a;
        pipe_wdata = d;
        pipe_we    = 1'b1;
        @(negedge clk);
        chk($sformatf("gnt_wr_%03h", a), 32'(pipe_gnt), 32'd1);
        @(posedge clk); #1;
        pipe_we = 1'b0;
    endtask

    task automatic pipe_rd(input logic [11:0] a, input logic [31:0] exp);
        pipe_addr = a;
        pipe_re   = 1'b1;
        @(negedge clk);
        chk($sformatf("gnt_rd_%03h", a), 32'(pipe_gnt), 32'd1);
        rd_q.push_back(exp);
        @(posedge clk); #1;
        pipe_re = 1'b0;
        @(negedge clk);
        chk($sformatf("rdata_%03h", a), pipe_rdata, rd_q.pop_front());
        @(posedge clk); #1;
    endtask

    // Called just after the edge where an event is presented.
    task automatic expect_accept(input bit push, input logic [31:0] tgt, input int lat);
        @(negedge clk);
        chk("ack", 32'(ack), 32'd1);
        if (push) sb_q.push_back('{tgt, cyc + lat});
        @(posedge clk); #1;
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("ack_pulse", 32'(ack), 32'd0);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 12'h340, 32'hDEAD_BEEF};
        tbl[1] = '{1'b0, 12'h340, 32'hDEAD_BEEF};
        tbl[2] = '{1'b1, 12'h305, 32'h8000_1000};
        tbl[3] = '{1'b1, 12'h300, 32'h0000_0008};
        tbl[4] = '{1'b0, 12'h305, 32'h8000_1000};
        tbl[5] = '{1'b0, 12'h300, 32'h0000_0008};

        rst_n = 1'b0; exc_valid = 1'b0; exc_cause = '0; exc_pc = '0;
        mret = 1'b0; irq = 1'b0; irq_pc = '0;
        pipe_addr = 12'h340; pipe_wdata = '0; pipe_re = 1'b1; pipe_we = 1'b0;

        // Reset state, with a pipeline read pending.
        repeat (2) @(negedge clk);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_gnt", 32'(pipe_gnt), 32'd0);
        chk("rst_csr_re", 32'(cif.csr_read_enable_o), 32'd0);
        pipe_re = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Pipeline passthrough table.
        for (int i = 0; i < 6; i++) begin
            if (tbl[i].we) pipe_wr(tbl[i].addr, tbl[i].data);
            else           pipe_rd(tbl[i].addr, tbl[i].data);
        end

        // Exception and mret together: exception wins.
        exc_valid = 1'b1; exc_cause = 5'd2; exc_pc = 32'h100; mret = 1'b1;
        expect_accept(1'b1, 32'h8000_1000, 6);
        exc_valid = 1'b0; mret = 1'b0;
        wait_idle("exc");
        chk("redirect_hold_valid", 32'(redirect_valid), 32'd0);
        chk("redirect_hold_pc", redirect_pc, 32'h8000_1000);
        pipe_rd(12'h341, 32'h0000_0100);
        pipe_rd(12'h342, 32'h0000_0002);
        pipe_rd(12'h300, 32'h0000_1880);

        // mret back to mepc, MIE restored.
        mret = 1'b1;
        expect_accept(1'b1, 32'h0000_0100, 4);
        mret = 1'b0;
        wait_idle("mret");
        pipe_rd(12'h300, 32'h0000_1888);

        // Interrupt pending but MIE clear: pipeline access proceeds.
        pipe_wr(12'h300, 32'h0000_0000);
        pipe_wr(12'h304, 32'h0000_0800);
        irq = 1'b1; irq_pc = 32'h200;
        pipe_addr = 12'h340; pipe_re = 1'b1;
        @(negedge clk);
        chk("irq_masked_ack", 32'(ack), 32'd0);
        chk("irq_masked_gnt", 32'(pipe_gnt), 32'd1);
        @(posedge clk); #1;
        pipe_re = 1'b0;
        @(negedge clk);
        chk("irq_masked_rdata", pipe_rdata, 32'hDEAD_BEEF);
        @(posedge clk); #1;

        // Enable MIE with irq held: taken right after the enabling write.
        pipe_wr(12'h305, 32'h8000_1001);
        pipe_wr(12'h300, 32'h0000_0008);
        expect_accept(1'b1, IRQ_TARGET, 6);
        irq = 1'b0;
        wait_idle("irq");
        pipe_rd(12'h342, 32'h8000_000B);
        pipe_rd(12'h341, 32'h0000_0200);
        pipe_rd(12'h300, 32'h0000_1880);

        // Reset during TRAP_WR_MCAUSE abandons the trap.
        pipe_wr(12'h300, 32'h0000_0008);
        exc_valid = 1'b1; exc_cause = 5'd5; exc_pc = 32'h300;
        expect_accept(1'b0, 32'h0, 0);
        exc_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_we", 32'(cif.csr_write_enable_o), 32'd1);
        chk("mid_addr", 32'(cif.csr_address_o), 32'h342);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_we", 32'(cif.csr_write_enable_o), 32'd0);
        chk("midrst_redirect_valid", 32'(redirect_valid), 32'd0);
        chk("midrst_redirect_pc", redirect_pc, 32'd0);
        chk("midrst_gnt", 32'(pipe_gnt), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        pipe_rd(12'h300, 32'h0000_0008);
        pipe_rd(12'h341, 32'h0000_0300);
        pipe_rd(12'h342, 32'h8000_000B);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
